// File: rtl/cifrador_pkg.sv
// Shared types and constants for the cipher serial transmit stage.
// The frame is 8N1: one start bit, eight data bits LSB first, one stop bit.
package cifrador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/cifrador_tx_serial_if.sv
// Valid/ready byte handshake from the cipher stage into the serial transmitter.
interface cifrador_tx_serial_if;
    import cifrador_pkg::*;

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cifrador_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head data.
// Pointers wrap modulo DEPTH; full and empty are told apart by the count.
module cifrador_byte_fifo
    import cifrador_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [DATA_BITS-1:0]   i_data,
    input  logic                   i_pop,
    output logic [DATA_BITS-1:0]   o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; a push and pop together leave the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/cifrador_tx_serial.sv
// Buffers ciphertext bytes and serialises them as 8N1 frames on a single line.
// Back-to-back bytes are chained from the last STOP cycle straight into START.
module cifrador_tx_serial
    import cifrador_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    cifrador_tx_serial_if.slave         in_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    tx_state_t            r_state;
    logic [BW-1:0]        r_baud;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;

    logic [DATA_BITS-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_last;

    assign w_baud_last     = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign in_if.in_ready  = !rst && !w_full;
    assign w_push          = in_if.in_valid && in_if.in_ready;
    assign tx              = r_tx;
    assign busy            = (r_state != IDLE) || (fifo_count != '0);

    // Pop the head either from IDLE or on the final STOP cycle for a gapless stream.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:    w_pop = !w_empty;
            STOP:    w_pop = w_baud_last && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    cifrador_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_if.in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Frame sequencer; tx is driven from a register so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= {IW{1'b0}};
            r_shift   <= {DATA_BITS{1'b0}};
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud    <= {BW{1'b0}};
                    r_bit_idx <= {IW{1'b0}};
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        r_baud    <= {BW{1'b0}};
                        r_bit_idx <= {IW{1'b0}};
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud    <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud <= {BW{1'b0}};
                        if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // Next bit is shift[1] because the register shifts on this same edge.
                            r_bit_idx <= r_bit_idx + IW'(1);
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        r_baud    <= {BW{1'b0}};
                        r_bit_idx <= {IW{1'b0}};
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_baud  <= {BW{1'b0}};
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cifrador_tx_serial.sv
// Directed bench for cifrador_tx_serial with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frames are stored as 10-bit words where bit k is the k-th bit on the line.
module tb_cifrador_tx_serial;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    cifrador_tx_serial_if bus ();

    cifrador_tx_serial #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs [0:4];
    logic [7:0] byt [0:7];
    int         off [0:7];
    logic [9:0] exp_frames [0:7];
    int         acc_at [0:7];
    logic       tx_h [0:299];
    logic       busy_h [0:299];
    logic       rdy_h [0:299];
    logic [2:0] cnt_h [0:299];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives byt[i] starting at edge E(off[i]) and records its acceptance edge.
    task automatic producer(input int nb, input int base);
        for (int i = 0; i < nb; i++) begin
            logic acc;
            int   guard;
            while (cyc < base + off[i]) tick();
            bus.in_data  = byt[i];
            bus.in_valid = 1'b1;
            acc_at[i]    = -1;
            guard        = 0;
            while (acc_at[i] < 0 && guard < 500) begin
                acc = bus.in_ready;
                tick();
                if (acc) acc_at[i] = cyc - base - 1;
                guard++;
            end
            if (acc_at[i] < 0) chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end
    endtask

    // Index n holds the outputs just after edge En.
    task automatic recorder(input int len);
        for (int n = 0; n < len; n++) begin
            tick();
            tx_h[n]   = tx;
            busy_h[n] = busy;
            rdy_h[n]  = bus.in_ready;
            cnt_h[n]  = fifo_count;
        end
    endtask

    task automatic run_scen(input int nb);
        int base;
        base = cyc;
        fork
            producer(nb, base);
            recorder(nb * FLEN + 2);
        join
    endtask

    task automatic check_stream(input int nb);
        chk("tx_before_pop", int'(tx_h[0]), 1);
        for (int n = 1; n <= nb * FLEN; n++) begin
            int f;
            int b;
            f = (n - 1) / FLEN;
            b = ((n - 1) % FLEN) / CPB;
            chk($sformatf("tx_f%0d_b%0d_e%0d", f, b, n), int'(tx_h[n]), int'(exp_frames[f][b]));
            chk($sformatf("busy_e%0d", n), int'(busy_h[n]), 1);
        end
        chk("tx_idle_after", int'(tx_h[nb * FLEN + 1]), 1);
        chk("busy_idle_after", int'(busy_h[nb * FLEN + 1]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'h3C, frame: 10'h278};
        vecs[4] = '{data: 8'h81, frame: 10'h302};

        // Power-up reset
        tick();
        tick();
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        tick();
        chk("rel_ready", int'(bus.in_ready), 1);

        // Reset for three cycles while idle
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_rst_tx", int'(tx), 1);
            chk("idle_rst_busy", int'(busy), 0);
            chk("idle_rst_count", int'(fifo_count), 0);
            chk("idle_rst_ready", int'(bus.in_ready), 0);
        end
        rst = 1'b0;
        tick();
        chk("idle_rel_ready", int'(bus.in_ready), 1);

        // Single-byte table
        for (int v = 0; v < 5; v++) begin
            byt[0]        = vecs[v].data;
            off[0]        = 0;
            exp_frames[0] = vecs[v].frame;
            run_scen(1);
            chk("single_acc", acc_at[0], 0);
            chk("single_cnt_e0", int'(cnt_h[0]), 1);
            chk("single_cnt_e1", int'(cnt_h[1]), 0);
            check_stream(1);
            tick();
        end

        // Back-to-back 0x00 then 0xFF
        byt[0] = 8'h00; off[0] = 0; exp_frames[0] = 10'h200;
        byt[1] = 8'hFF; off[1] = 1; exp_frames[1] = 10'h3FE;
        run_scen(2);
        chk("b2b_acc1", acc_at[1], 1);
        chk("b2b_cnt_e1", int'(cnt_h[1]), 1);
        chk("b2b_cnt_e41", int'(cnt_h[41]), 0);
        check_stream(2);
        tick();

        // Backpressure: six bytes with in_valid held
        byt[0] = 8'h11; exp_frames[0] = 10'h222;
        byt[1] = 8'h22; exp_frames[1] = 10'h244;
        byt[2] = 8'h33; exp_frames[2] = 10'h266;
        byt[3] = 8'h44; exp_frames[3] = 10'h288;
        byt[4] = 8'h55; exp_frames[4] = 10'h2AA;
        byt[5] = 8'h66; exp_frames[5] = 10'h2CC;
        for (int i = 0; i < 6; i++) off[i] = 0;
        run_scen(6);
        chk("bp_acc5", acc_at[4], 4);
        chk("bp_acc6", acc_at[5], 42);
        chk("bp_cnt_full", int'(cnt_h[4]), 4);
        chk("bp_ready_low", int'(rdy_h[4]), 0);
        chk("bp_ready_low_e40", int'(rdy_h[40]), 0);
        chk("bp_cnt_after_pop", int'(cnt_h[41]), 3);
        chk("bp_ready_back", int'(rdy_h[41]), 1);
        chk("bp_cnt_refill", int'(cnt_h[42]), 4);
        check_stream(6);
        tick();

        // Push lands on the same edge as the STOP->START pop
        byt[0] = 8'hA1; off[0] = 0;  exp_frames[0] = 10'h342;
        byt[1] = 8'hB2; off[1] = 1;  exp_frames[1] = 10'h364;
        byt[2] = 8'hC3; off[2] = 2;  exp_frames[2] = 10'h386;
        byt[3] = 8'hD4; off[3] = 3;  exp_frames[3] = 10'h3A8;
        byt[4] = 8'hE5; off[4] = 41; exp_frames[4] = 10'h3CA;
        run_scen(5);
        chk("sim_acc", acc_at[4], 41);
        chk("sim_cnt_before", int'(cnt_h[40]), 3);
        chk("sim_cnt_after", int'(cnt_h[41]), 3);
        check_stream(5);
        tick();

        // Reset during DATA bit 3 with two bytes queued
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        tick();
        bus.in_data  = 8'h02;
        tick();
        bus.in_data  = 8'h03;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("mid_cnt_before", int'(fifo_count), 2);
        chk("mid_tx_bit3", int'(tx), 0);
        chk("mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_cnt", int'(fifo_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        begin
            int lows;
            int busies;
            lows   = 0;
            busies = 0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (tx !== 1'b1) lows++;
                if (busy !== 1'b0) busies++;
            end
            chk("mid_no_frames", lows, 0);
            chk("mid_no_busy", busies, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
